// File: rtl/case_pkg.sv
// Shared types and helpers for the streaming ASCII case converter.
//   mode_e    : per-packet conversion mode (PASS/UPPER/LOWER/TOGGLE)
//   conv_t    : result of converting one byte (new byte + changed flag)
//   conv_byte : converts one character according to a mode
//   ST_*      : packet FSM state encodings
package case_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    UPPER  = 2'b01,
    LOWER  = 2'b10,
    TOGGLE = 2'b11
  } mode_e;

  localparam logic [7:0] LC_A     = 8'h61;
  localparam logic [7:0] LC_Z     = 8'h7A;
  localparam logic [7:0] UC_A     = 8'h41;
  localparam logic [7:0] UC_Z     = 8'h5A;
  localparam logic [7:0] CASE_BIT = 8'h20;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  typedef struct packed {
    logic [7:0] data;
    logic       changed;
  } conv_t;

  function automatic conv_t conv_byte(input mode_e mode, input logic [7:0] b);
    conv_t r;
    logic  is_lc;
    logic  is_uc;
    is_lc     = (b >= LC_A) && (b <= LC_Z);
    is_uc     = (b >= UC_A) && (b <= UC_Z);
    r.data    = b;
    r.changed = 1'b0;
    case (mode)
      UPPER: if (is_lc) begin
        r.data    = b - CASE_BIT;
        r.changed = 1'b1;
      end
      LOWER: if (is_uc) begin
        r.data    = b + CASE_BIT;
        r.changed = 1'b1;
      end
      TOGGLE: if (is_lc || is_uc) begin
        // Letters differ from their other case only in bit 5.
        r.data    = b ^ CASE_BIT;
        r.changed = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/case_skid_buf.sv
// Two-entry valid/ready register slice: an output register plus one skid
// register, so in_ready comes straight from a flop.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake, in_payload accepted on valid&&ready
//   out_valid/out_ready    downstream handshake, out_payload taken on valid&&ready
//   in_payload/out_payload W-bit payload, never lost, duplicated or reordered
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1.
// A source keeps valid and payload stable until that edge; this slice keeps
// out_valid and out_payload stable while out_valid=1 and out_ready=0.
module case_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         skid_valid;
  logic [W-1:0] skid_payload;
  logic         ready_q;
  logic         accept;
  logic         out_free;
  logic         skid_next;

  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q;
  // The output register can take a new beat if it is empty or being read.
  assign out_free = !out_valid || out_ready;

  always_comb begin
    skid_next = 1'b0;
    if (!out_free) skid_next = skid_valid || accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
      ready_q      <= 1'b0;
    end else begin
      if (out_free) begin
        // A held skid beat is older than anything at the input, so it goes
        // first; in_ready is low whenever the skid is full.
        if (skid_valid) begin
          out_valid   <= 1'b1;
          out_payload <= skid_payload;
          skid_valid  <= 1'b0;
        end else if (accept) begin
          out_valid   <= 1'b1;
          out_payload <= in_payload;
        end else begin
          out_valid   <= 1'b0;
        end
      end else if (accept) begin
        skid_valid   <= 1'b1;
        skid_payload <= in_payload;
      end
      ready_q <= !skid_next;
    end
  end

endmodule

// File: rtl/ascii_case_stream.sv
// Streaming multi-lane ASCII case converter with a per-packet mode.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mode_i                00 PASS, 01 UPPER, 10 LOWER, 11 TOGGLE; taken per packet
//   in_valid/in_ready     input handshake (beat accepted on valid&&ready)
//   in_data/keep/last     LANES characters, lane 0 first; keep per lane; packet end
//   out_valid/out_ready   output handshake
//   out_data/keep/last    converted characters, keep and last delayed with them
//   cnt_clr               synchronous clear of conv_count (beats a same-cycle increment)
//   conv_count            saturating count of lanes whose byte changed
//   in_packet             high between the first and the last accepted beat of a packet
//   fsm_state             packet FSM state (ST_IDLE / ST_IN_PKT) for observation
module ascii_case_stream
  import case_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_keep,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conv_count,
  output logic               in_packet,
  output logic [0:0]         fsm_state
);

  localparam int NW = $clog2(LANES + 1);
  localparam int PW = 8 * LANES + LANES + 1;

  logic [0:0]         state;
  mode_e              mode_q;
  mode_e              eff_mode;
  logic               accept;
  logic [8*LANES-1:0] conv_data;
  logic [LANES-1:0]   lane_chg;
  logic [NW-1:0]      n_chg;
  logic [CNT_W:0]     sum;
  logic [PW-1:0]      buf_out;

  assign accept    = in_valid && in_ready;
  assign in_packet = (state == ST_IN_PKT);
  assign fsm_state = state;

  // The first beat of a packet (and a single-beat packet) uses mode_i live;
  // later beats use the mode captured from that first beat.
  assign eff_mode = (state == ST_IN_PKT) ? mode_q : mode_e'(mode_i);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    conv_t c;
    assign c                   = conv_byte(eff_mode, in_data[8*k +: 8]);
    assign conv_data[8*k +: 8] = in_keep[k] ? c.data : 8'h00;
    assign lane_chg[k]         = in_keep[k] & c.changed;
  end

  always_comb begin
    n_chg = '0;
    for (int k = 0; k < LANES; k++) n_chg = n_chg + NW'(lane_chg[k]);
  end

  assign sum = {1'b0, conv_count} + (CNT_W+1)'(n_chg);

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_count <= '0;
    end else if (cnt_clr) begin
      conv_count <= '0;
    end else if (accept) begin
      conv_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= PASS;
    end else if (accept) begin
      case (state)
        ST_IDLE: if (!in_last) begin
          state  <= ST_IN_PKT;
          mode_q <= mode_e'(mode_i);
        end
        ST_IN_PKT: if (in_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  case_skid_buf #(.W(PW)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload ({conv_data, in_keep, in_last}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(buf_out)
  );

  assign out_data = buf_out[PW-1 -: 8*LANES];
  assign out_keep = buf_out[LANES:1];
  assign out_last = buf_out[0];

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: a 4-lane/16-bit-counter instance checked by a
// scoreboard fed from a character-level reference model, and a 1-lane/4-bit
// instance for the byte stream and counter saturation scenarios.
module tb_ascii_case_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // 4-lane instance
  logic        rst4 = 1'b1, in_valid4 = 1'b0, in_last4 = 1'b0, out_ready4 = 1'b0, cnt_clr4 = 1'b0;
  logic [1:0]  mode4 = 2'b00;
  logic [31:0] in_data4 = '0;
  logic [3:0]  in_keep4 = '0;
  logic        in_ready4, out_valid4, out_last4, in_packet4;
  logic [31:0] out_data4;
  logic [3:0]  out_keep4;
  logic [15:0] count4;
  logic [0:0]  state4;

  // 1-lane instance
  logic        rst1 = 1'b1, in_valid1 = 1'b0, in_last1 = 1'b0, out_ready1 = 1'b0, cnt_clr1 = 1'b0;
  logic [1:0]  mode1 = 2'b00;
  logic [7:0]  in_data1 = '0;
  logic [0:0]  in_keep1 = '0;
  logic        in_ready1, out_valid1, out_last1, in_packet1;
  logic [7:0]  out_data1;
  logic [0:0]  out_keep1;
  logic [3:0]  count1;
  logic [0:0]  state1;

  ascii_case_stream #(.LANES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst4), .mode_i(mode4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_keep(in_keep4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_keep(out_keep4), .out_last(out_last4),
    .cnt_clr(cnt_clr4), .conv_count(count4), .in_packet(in_packet4), .fsm_state(state4)
  );

  ascii_case_stream #(.LANES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .mode_i(mode1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_keep(in_keep1), .in_last(in_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_keep(out_keep1), .out_last(out_last1),
    .cnt_clr(cnt_clr1), .conv_count(count1), .in_packet(in_packet1), .fsm_state(state1)
  );

  // ---------------- reference model ----------------
  // Character-level rule: mode 1 upper-cases letters, 2 lower-cases, 3 swaps, 0 passes.
  function automatic logic [7:0] ref_char(input logic [1:0] mode, input logic [7:0] c, output int changed);
    bit is_lower;
    bit is_upper;
    is_lower = (c >= 8'd97) && (c <= 8'd122);   // 'a'..'z'
    is_upper = (c >= 8'd65) && (c <= 8'd90);    // 'A'..'Z'
    changed  = 0;
    ref_char = c;
    if ((mode == 2'd1 || mode == 2'd3) && is_lower) begin
      ref_char = c - 8'd32;
      changed  = 1;
    end else if ((mode == 2'd2 || mode == 2'd3) && is_upper) begin
      ref_char = c + 8'd32;
      changed  = 1;
    end
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(65, 90));
      2:       return 8'($urandom_range(97, 122));
      default: return 8'($urandom_range(32, 64));
    endcase
  endfunction

  // ---------------- scoreboard (4-lane instance) ----------------
  logic [36:0] exp_q[$];
  int          exp_cnt   = 0;
  bit          m_in_pkt  = 0;
  logic [1:0]  m_mode    = 2'b00;
  bit          mon_en    = 0;
  bit          stall_prev = 0;
  logic [36:0] held;

  always @(negedge clk) begin
    logic [36:0] e;
    logic [31:0] ed;
    logic [1:0]  m;
    int          ch;
    int          nch;
    if (mon_en) begin
      if (rst4) begin
        exp_q.delete();
        exp_cnt    = 0;
        m_in_pkt   = 0;
        stall_prev = 0;
      end else begin
        total++;
        if (count4 !== 16'(exp_cnt)) begin
          bad++; $display("FAIL sb_count got=%0d exp=%0d t=%0t", count4, exp_cnt, $time);
        end
        total++;
        if (in_packet4 !== m_in_pkt) begin
          bad++; $display("FAIL sb_in_packet got=%b exp=%b t=%0t", in_packet4, m_in_pkt, $time);
        end
        if (stall_prev) begin
          total++;
          if (out_valid4 !== 1'b1 || {out_data4, out_keep4, out_last4} !== held) begin
            bad++; $display("FAIL sb_hold got=%b/%h exp=1/%h t=%0t", out_valid4, {out_data4, out_keep4, out_last4}, held, $time);
          end
        end
        if (out_valid4 && out_ready4) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_extra got=%h exp=none t=%0t", {out_data4, out_keep4, out_last4}, $time);
          end else begin
            e = exp_q.pop_front();
            if ({out_data4, out_keep4, out_last4} !== e) begin
              bad++; $display("FAIL sb_data got=%h exp=%h t=%0t", {out_data4, out_keep4, out_last4}, e, $time);
            end
          end
        end
        stall_prev = out_valid4 && !out_ready4;
        held       = {out_data4, out_keep4, out_last4};
        nch = 0;
        if (in_valid4 && in_ready4) begin
          m  = m_in_pkt ? m_mode : mode4;
          ed = '0;
          for (int k = 0; k < 4; k++) begin
            if (in_keep4[k]) begin
              ed[8*k +: 8] = ref_char(m, in_data4[8*k +: 8], ch);
              nch += ch;
            end
          end
          exp_q.push_back({ed, in_keep4, in_last4});
          if (!m_in_pkt && !in_last4) begin
            m_in_pkt = 1;
            m_mode   = mode4;
          end else if (m_in_pkt && in_last4) begin
            m_in_pkt = 0;
          end
        end
        if (cnt_clr4) exp_cnt = 0;
        else if (in_valid4 && in_ready4) exp_cnt = (exp_cnt + nch > 65535) ? 65535 : exp_cnt + nch;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] m);
    bit acc = 0;
    int n   = 0;
    in_valid4 = 1'b1; in_data4 = d; in_keep4 = k; in_last4 = l; mode4 = m;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready4;
      @(posedge clk); #1; n++;
    end
    in_valid4 = 1'b0;
    if (!acc) begin
      total++; bad++; $display("FAIL send4_timeout got=no_accept exp=accept t=%0t", $time);
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic l, input logic [1:0] m);
    bit acc = 0;
    int n   = 0;
    in_valid1 = 1'b1; in_data1 = d; in_keep1 = 1'b1; in_last1 = l; mode1 = m;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready1;
      @(posedge clk); #1; n++;
    end
    in_valid1 = 1'b0;
    if (!acc) begin
      total++; bad++; $display("FAIL send1_timeout got=no_accept exp=accept t=%0t", $time);
    end
  endtask

  task automatic drain4();
    int n = 0;
    out_ready4 = 1'b1;
    while ((exp_q.size() != 0 || out_valid4) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clear4();
    cnt_clr4 = 1'b1;
    @(posedge clk); #1;
    cnt_clr4 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst4 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid4, in_ready4, in_packet4, out_last4} !== 4'b0000 || count4 !== 16'd0 || out_data4 !== 32'd0 || out_keep4 !== 4'd0) begin
      bad++; $display("FAIL reset4 got=%b%b%b%b/%h/%h/%h exp=0000/0/0/0", out_valid4, in_ready4, in_packet4, out_last4, count4, out_data4, out_keep4);
    end
    total++;
    if ({out_valid1, in_ready1, in_packet1, out_last1} !== 4'b0000 || count1 !== 4'd0 || out_data1 !== 8'd0) begin
      bad++; $display("FAIL reset1 got=%b%b%b%b/%h/%h exp=0000/0/0", out_valid1, in_ready1, in_packet1, out_last1, count1, out_data1);
    end
    rst4 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b%b exp=11", in_ready4, in_ready1);
    end
    mon_en = 1;
  endtask

  task automatic test_hello();
    logic [7:0] src [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [7:0] dst [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    out_ready1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send1(src[i], i == 4, 2'b01);
      total++;
      if (out_valid1 !== 1'b1 || out_data1 !== dst[i] || out_last1 !== (i == 4)) begin
        bad++; $display("FAIL hello_%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid1, out_data1, out_last1, dst[i], i == 4);
      end
    end
    total++;
    if (count1 !== 4'd5) begin
      bad++; $display("FAIL hello_count got=%0d exp=5", count1);
    end
  endtask

  task automatic test_toggle_keep();
    drain4();
    clear4();
    send4(32'h2C7A4128, 4'b1111, 1'b1, 2'b11);
    total++;
    if (out_valid4 !== 1'b1 || out_data4 !== 32'h2C5A6128 || count4 !== 16'd2) begin
      bad++; $display("FAIL toggle_full got=%b/%h/%0d exp=1/2c5a6128/2", out_valid4, out_data4, count4);
    end
    send4(32'h2C7A4128, 4'b0101, 1'b1, 2'b11);
    total++;
    if (out_data4 !== 32'h005A0028 || out_keep4 !== 4'b0101 || count4 !== 16'd3) begin
      bad++; $display("FAIL toggle_keep got=%h/%b/%0d exp=005a0028/0101/3", out_data4, out_keep4, count4);
    end
  endtask

  task automatic test_backpressure();
    bit saw_low = 0;
    drain4();
    fork
      begin
        for (int i = 0; i < 10; i++)
          send4({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 4'hF, i == 9, 2'b01);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready4 = 1'b0;
        repeat (3) begin
          @(negedge clk); if (!in_ready4) saw_low = 1;
          @(posedge clk);
        end
        #1 out_ready4 = 1'b1;
      end
    join
    total++;
    if (!saw_low) begin
      bad++; $display("FAIL bp_ready_fall got=ready_stayed_high exp=ready_low");
    end
    drain4();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_lost got=%0d_pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_mode_latch();
    drain4();
    send4(32'h64636261, 4'hF, 1'b0, 2'b01);
    total++;
    if (out_data4 !== 32'h44434241 || in_packet4 !== 1'b1 || state4 !== 1'b1) begin
      bad++; $display("FAIL mode_b0 got=%h/%b/%b exp=44434241/1/1", out_data4, in_packet4, state4);
    end
    send4(32'h68676665, 4'hF, 1'b0, 2'b00);
    total++;
    if (out_data4 !== 32'h48474645) begin
      bad++; $display("FAIL mode_b1 got=%h exp=48474645", out_data4);
    end
    send4(32'h6C6B6A69, 4'hF, 1'b1, 2'b00);
    total++;
    if (out_data4 !== 32'h4C4B4A49 || in_packet4 !== 1'b0) begin
      bad++; $display("FAIL mode_b2 got=%h/%b exp=4c4b4a49/0", out_data4, in_packet4);
    end
    send4(32'h706F6E6D, 4'hF, 1'b1, 2'b00);
    total++;
    if (out_data4 !== 32'h706F6E6D) begin
      bad++; $display("FAIL mode_next got=%h exp=706f6e6d", out_data4);
    end
  endtask

  task automatic test_saturate();
    cnt_clr1 = 1'b1;
    @(posedge clk); #1;
    cnt_clr1 = 1'b0;
    total++;
    if (count1 !== 4'd0) begin
      bad++; $display("FAIL sat_clear got=%0d exp=0", count1);
    end
    for (int i = 0; i < 20; i++) send1(8'(8'h61 + i), i == 19, 2'b01);
    total++;
    if (count1 !== 4'hF) begin
      bad++; $display("FAIL sat_hold got=%h exp=f", count1);
    end
    cnt_clr1 = 1'b1;
    send1(8'h62, 1'b1, 2'b01);
    cnt_clr1 = 1'b0;
    total++;
    if (count1 !== 4'd0 || out_data1 !== 8'h42) begin
      bad++; $display("FAIL sat_clr_wins got=%h/%h exp=0/42", count1, out_data1);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    drain4();
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send4({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 4'($urandom_range(0, 15)), (i % 4) == 3, 2'($urandom_range(0, 3)));
    total++;
    if (cyc - c0 != 16) begin
      bad++; $display("FAIL b2b_cycles got=%0d exp=16", cyc - c0);
    end
  endtask

  task automatic test_random();
    bit done = 0;
    drain4();
    fork
      begin
        for (int i = 0; i < 300; i++)
          send4({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready4 = ($urandom_range(0, 2) != 0);
          cnt_clr4   = ($urandom_range(0, 15) == 0);
        end
        cnt_clr4 = 1'b0;
      end
    join
    drain4();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_lost got=%0d_pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    drain4();
    out_ready4 = 1'b0;
    send4(32'h64636261, 4'hF, 1'b0, 2'b01);
    send4(32'h68676665, 4'hF, 1'b0, 2'b01);
    rst4 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid4 !== 1'b0 || count4 !== 16'd0 || in_packet4 !== 1'b0 || in_ready4 !== 1'b0) begin
      bad++; $display("FAIL midrst got=%b/%0d/%b/%b exp=0/0/0/0", out_valid4, count4, in_packet4, in_ready4);
    end
    rst4 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready4 !== 1'b1) begin
      bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready4);
    end
    out_ready4 = 1'b1;
    send4(32'h64636261, 4'hF, 1'b1, 2'b00);
    total++;
    if (out_valid4 !== 1'b1 || out_data4 !== 32'h64636261 || in_packet4 !== 1'b0) begin
      bad++; $display("FAIL midrst_new got=%b/%h/%b exp=1/64636261/0", out_valid4, out_data4, in_packet4);
    end
    drain4();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hello();
    test_toggle_keep();
    test_backpressure();
    test_mode_latch();
    test_saturate();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
